sha256_second_block_pipe: RTL and testbench
===========================================

// Module: sha256_second_block_pipe
// PURPOSE
// - Fully unrolled, one-result-per-clock SHA-256 compression pipeline for the
//   second 64-byte block of an 80-byte Bitcoin header (fixed padding).
// - Takes the precomputed midstate, that midstate advanced by round 0, and the
//   128-bit header tail. Returns midstate + compressed state.
// - Feeds the double-SHA stage of the miner core.
// PARAMETERS
// - none (round count 64, K constants and padding are fixed)
// PORTS
// CLK            in   1    clock, all state updates on rising edge
// RST            in   1    synchronous, active-low reset
// write_en       in   1    sample inputs this cycle; tags the pipeline slot valid
// digest_intial  in   256  midstate H0..H7 ({a..h}, a in [255:224]); final add term
// digest_in      in   256  midstate after round 0 (W0 = block_in[127:96]) already applied
// block_in       in   128  header tail W0..W3, W0 = [127:96], big-endian words
// digest_out     out  256  registered result {H0'..H7'}
// valid_out      out  1    digest_out holds a result from a write_en=1 sample
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-low.
// - Message words: W0..W3 = block_in, W4 = 32'h80000000, W5..W14 = 0,
//   W15 = 32'h00000280. W16..W63 use the standard schedule:
//   W_t = s1(W_t-2) + W_t-7 + s0(W_t-15) + W_t-16, all adds mod 2^32.
// - Edge E0: input register captures digest_in, block_in and write_en.
// - Stage k (k = 1..63) is one combinational SHA-256 round with K_k and W_k.
//   It operates on its own registered state {a..h} plus a 16-word schedule
//   window. Stage k's output is combinationally valid after edge E_k.
// - Stage k's output is registered into stage k+1 at edge E_k+1.
// - Each stage derives its next W on the fly from the window it carries.
// - Round: T1 = h + S1(e) + Ch(e,f,g) + K + W, T2 = S0(a) + Maj(a,b,c).
//   New state = {T1+T2, a, b, c, d+T1, e, f, g}, all mod 2^32.
// - Output (edge E64): digest_out <= per-word mod-2^32 sum of the stage-63
//   state and digest_intial.
// - Latency is 64 clocks from the sampling edge to digest_out. Throughput is
//   1 per clock, with independent inputs accepted on consecutive cycles.
// - digest_intial is not pipelined. It must be held stable for the whole job;
//   it is constant per midstate.
// - valid bit: write_en travels a 64-deep shift pipeline beside the data.
//   valid_out is asserted with the matching digest_out.
// - write_en=0 cycles still advance the pipeline; the slot is marked invalid.
// - Reset (RST=0 at an edge): all valid bits, valid_out and digest_out go to 0.
//   Data stage registers may clear or hold.
// - Reset mid-operation: every in-flight result is discarded.
// - valid_out first rises 64 clocks after the first write_en=1 sample after reset.
// TESTING
// Default stimulus: digest_intial=F59007B57A2E5616B8F47922F4A62AA5F6F596588185BBAEFA09E7763BC75771,
//   digest_in=F7A528B9F59007B57A2E5616B8F47922F2C1816DF6F596588185BBAEFA09E776,
//   block_in=252db801130dae516461011a3aeb9bb8, write_en=1 held
// 1 Stage check, same stimulus:
//   stage1 out after E1 = 10F2957CF7A528B9F59007B57A2E561625BEF710F2C1816DF6F596588185BBAE
//   stage2 out after E2 = 678CD63410F2957CF7A528B9F59007B58681540525BEF710F2C1816DF6F59658
//   stage3 out after E3 = 79162787678CD63410F2957CF7A528B95BE8C28B8681540525BEF710F2C1816D
//   stage4 out after E4 = 878B488079162787678CD63410F2957C52B97D515BE8C28B8681540525BEF710
// 2 Stage 63 out after E63 = E60E116DBB0F2D17486456C9776FD9E6E93412D5250EF7B412FB586039701CF6
// 3 After E64: digest_out = DB9E1922353D832D0158CFEB6C16048BE029A92DA694B3620D053FD675377467,
//   valid_out = 1
// 4 Change block_in to ...3aeb9bb9 (nonce+1). 64 clocks later:
//   digest_out = B677077F3EC92273F319D7C6217F79FE8A4A977D93E7A4BDF8EF1B0D6C936D6C
// 5 Back-to-back nonces on consecutive cycles -> correct results on consecutive
//   cycles.
//   Drop write_en for one cycle -> valid_out low exactly one cycle, 64 clocks later.
// 6 Assert RST mid-stream -> next edge valid_out=0 and digest_out=0.
//   Results resume 64 clocks after new samples.

Source files
------------

// File: rtl/sha256_second_block_pipe_if.sv
// Port bundle for the second-block SHA-256 pipeline.
// The master drives the job inputs, and the slave (the pipeline) returns the digest.
interface sha256_second_block_pipe_if;
    logic         write_en;
    logic [255:0] digest_intial;
    logic [255:0] digest_in;
    logic [127:0] block_in;
    logic [255:0] digest_out;
    logic         valid_out;

    modport master (
        output write_en, digest_intial, digest_in, block_in,
        input  digest_out, valid_out
    );

    modport slave (
        input  write_en, digest_intial, digest_in, block_in,
        output digest_out, valid_out
    );
endinterface

// File: rtl/sha256_second_block_pipe.sv
// Fully unrolled SHA-256 compression of the padded second block of an 80-byte header.
// It accepts one job per clock and returns midstate + compressed state 64 clocks later.
module sha256_second_block_pipe (
    input  logic                         CLK,
    input  logic                         RST,
    sha256_second_block_pipe_if.slave    bus
);
    localparam int STAGES = 64;

    typedef logic [15:0][31:0] win_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // state_p[k] holds the state after round k; state_p[0] is the captured round-0 midstate.
    logic [255:0]      state_p [0:STAGES-1];
    win_t              win_p   [0:STAGES-2];
    logic [STAGES-1:0] vld_p;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k,
                                               input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + big_s1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // The window entering round k holds W[k-1] in word 0 through W[k+14] in word 15.
    function automatic win_t init_window(input logic [127:0] blk);
        win_t w;
        w     = '0;
        w[0]  = blk[127:96];
        w[1]  = blk[95:64];
        w[2]  = blk[63:32];
        w[3]  = blk[31:0];
        w[4]  = 32'h80000000;
        w[15] = 32'h00000280;
        return w;
    endfunction

    function automatic win_t next_window(input win_t w);
        win_t n;
        for (int i = 0; i < 15; i++) n[i] = w[i + 1];
        n[15] = small_s1(w[14]) + w[9] + small_s0(w[1]) + w[0];
        return n;
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return r;
    endfunction

    always_ff @(posedge CLK) begin
        // Edge E0: input capture
        state_p[0] <= bus.digest_in;
        win_p[0]   <= init_window(bus.block_in);
        // Edges E1..E63: one round per stage
        for (int k = 1; k < STAGES; k++) begin
            state_p[k] <= sha_round(state_p[k-1], K[k], win_p[k-1][1]);
        end
        for (int k = 1; k < STAGES - 1; k++) begin
            win_p[k] <= next_window(win_p[k-1]);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            vld_p          <= '0;
            bus.valid_out  <= 1'b0;
            bus.digest_out <= '0;
        end else begin
            vld_p          <= {vld_p[STAGES-2:0], bus.write_en};
            // Edge E64: feed-forward add of the midstate
            bus.valid_out  <= vld_p[STAGES-1];
            bus.digest_out <= add8(state_p[STAGES-1], bus.digest_intial);
        end
    end
endmodule

// File: tb/tb_sha256_second_block_pipe.sv
// Directed bench for sha256_second_block_pipe.
// It covers reset, stage taps, latency, back-to-back jobs, valid gaps and mid-stream reset.
module tb_sha256_second_block_pipe;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sha256_second_block_pipe_if bus();

    sha256_second_block_pipe dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    localparam logic [255:0] INIT  = 256'hF59007B57A2E5616B8F47922F4A62AA5F6F596588185BBAEFA09E7763BC75771;
    localparam logic [255:0] MID   = 256'hF7A528B9F59007B57A2E5616B8F47922F2C1816DF6F596588185BBAEFA09E776;
    localparam logic [127:0] BLK_A = 128'h252db801130dae516461011a3aeb9bb8;
    localparam logic [127:0] BLK_B = 128'h252db801130dae516461011a3aeb9bb9;
    localparam logic [255:0] ST1   = 256'h10F2957CF7A528B9F59007B57A2E561625BEF710F2C1816DF6F596588185BBAE;
    localparam logic [255:0] ST2   = 256'h678CD63410F2957CF7A528B9F59007B58681540525BEF710F2C1816DF6F59658;
    localparam logic [255:0] ST3   = 256'h79162787678CD63410F2957CF7A528B95BE8C28B8681540525BEF710F2C1816D;
    localparam logic [255:0] ST4   = 256'h878B488079162787678CD63410F2957C52B97D515BE8C28B8681540525BEF710;
    localparam logic [255:0] ST63  = 256'hE60E116DBB0F2D17486456C9776FD9E6E93412D5250EF7B412FB586039701CF6;
    localparam logic [255:0] DIG_A = 256'hDB9E1922353D832D0158CFEB6C16048BE029A92DA694B3620D053FD675377467;
    localparam logic [255:0] DIG_B = 256'hB677077F3EC92273F319D7C6217F79FE8A4A977D93E7A4BDF8EF1B0D6C936D6C;

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic seen;
        int   lat;

        rst_n             = 1'b0;
        bus.write_en      = 1'b0;
        bus.digest_intial = INIT;
        bus.digest_in     = MID;
        bus.block_in      = BLK_A;
        repeat (3) tick();
        chk_int("reset_valid", int'(bus.valid_out), 0);
        chk256("reset_digest", bus.digest_out, '0);

        // Fill with nonce A; the first posedge after release is E0.
        rst_n        = 1'b1;
        bus.write_en = 1'b1;
        tick();
        tick(); chk256("stage1", dut.state_p[1], ST1);
        tick(); chk256("stage2", dut.state_p[2], ST2);
        tick(); chk256("stage3", dut.state_p[3], ST3);
        tick(); chk256("stage4", dut.state_p[4], ST4);
        seen = 1'b0;
        repeat (58) begin
            tick();
            seen = seen | bus.valid_out;
        end
        tick();
        chk256("stage63", dut.state_p[63], ST63);
        chk_int("valid_early", int'(seen | bus.valid_out), 0);
        tick();
        chk256("digest_a", bus.digest_out, DIG_A);
        chk_int("valid_e64", int'(bus.valid_out), 1);

        // Sample pattern B, A, B, gap, then A held, at edges E65..E69.
        bus.block_in = BLK_B; tick();
        bus.block_in = BLK_A; tick();
        bus.block_in = BLK_B; tick();
        bus.write_en = 1'b0;  tick();
        bus.write_en = 1'b1;
        bus.block_in = BLK_A; tick();
        repeat (59) tick();
        chk256("b2b_e128_a", bus.digest_out, DIG_A);
        tick(); chk256("b2b_e129_b", bus.digest_out, DIG_B);
        chk_int("b2b_e129_valid", int'(bus.valid_out), 1);
        tick(); chk256("b2b_e130_a", bus.digest_out, DIG_A);
        tick(); chk256("b2b_e131_b", bus.digest_out, DIG_B);
        tick(); chk_int("gap_valid_low", int'(bus.valid_out), 0);
        tick(); chk_int("gap_valid_back", int'(bus.valid_out), 1);
        chk256("gap_digest_a", bus.digest_out, DIG_A);

        // Reset with a full pipeline; every in-flight job must vanish.
        rst_n = 1'b0;
        tick();
        chk_int("midrst_valid", int'(bus.valid_out), 0);
        chk256("midrst_digest", bus.digest_out, '0);
        rst_n        = 1'b1;
        bus.write_en = 1'b0;
        seen = 1'b0;
        repeat (70) begin
            tick();
            seen = seen | bus.valid_out;
        end
        chk_int("midrst_discard", int'(seen), 0);

        // A single job after reset: count the edges from its sampling edge to valid_out.
        bus.block_in = BLK_B;
        bus.write_en = 1'b1;
        tick();
        bus.write_en = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.valid_out && lat < 80);
        chk_int("resume_latency", lat, 64);
        chk256("resume_digest", bus.digest_out, DIG_B);
        tick();
        chk_int("resume_single", int'(bus.valid_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
